// File: rtl/fcore_isa.sv
// Shared fCore ISA definitions: sequencer state encoding and the LDC pair advance.
package fcore_isa;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      RESOLVE,
      EFI_WAIT,
      DONE
   } sequencer_state_t;

   localparam int unsigned LDC_ADVANCE = 2;

endpackage

// File: rtl/fcore_channel_counter.sv
// Channel sweep counter: wraps to zero after reaching 'last', with synchronous clear.
module fcore_channel_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] last,
   output logic [WIDTH-1:0] count,
   output logic             terminal
);

   assign terminal = (count == last);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= terminal ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/fcore_program_sequencer.sv
// fCore program sequencer: sweeps each instruction across active channels, advances the
// program counter (by 2 on LDC pairs) and freezes issue while an EFI call is outstanding.
module fcore_program_sequencer
   import fcore_isa::*;
#(
   parameter int unsigned PROGRAM_DEPTH = 4096,
   parameter int unsigned MAX_CHANNELS  = 255
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             run,
   input  logic [$clog2(PROGRAM_DEPTH):0]   program_size,
   input  logic [$clog2(MAX_CHANNELS)-1:0]  n_channels,
   input  logic                             immediate_advance,
   input  logic                             efi_call,
   input  logic                             efi_done,
   output logic [$clog2(PROGRAM_DEPTH)-1:0] program_address,
   output logic [$clog2(MAX_CHANNELS)-1:0]  channel_address,
   output logic                             issue_valid,
   output logic                             busy,
   output logic                             done
);

   localparam int unsigned AW = $clog2(PROGRAM_DEPTH);
   localparam int unsigned CW = $clog2(MAX_CHANNELS);
   localparam int unsigned SW = AW + 2;

   sequencer_state_t state;
   sequencer_state_t ret_state;
   logic [AW:0]      pc;
   logic [AW:0]      size_q;
   logic [CW-1:0]    ch_last;
   logic [CW-1:0]    ch;
   logic             ch_terminal;
   logic             ch_clear;
   logic             ch_en;
   logic             ldc_pend;
   logic             efi_taken;
   logic             efi_trig;
   logic             single;
   logic [SW-1:0]    next_pc;
   logic             finish;

   // One spare bit on the sum so an LDC overhanging the last word still compares correctly.
   always_comb begin
      efi_trig = efi_call && !efi_taken;
      single   = (ch_last == '0);
      next_pc  = {1'b0, pc} + ((ldc_pend || immediate_advance) ? SW'(LDC_ADVANCE) : SW'(1));
      finish   = (next_pc >= {1'b0, size_q});
      ch_clear = (state == IDLE) && run;
      ch_en    = (state == RUN) && !efi_trig && !single;
   end

   fcore_channel_counter #(
      .WIDTH (CW)
   ) u_channel_counter (
      .clock    (clock),
      .reset    (reset),
      .clear    (ch_clear),
      .enable   (ch_en),
      .last     (ch_last),
      .count    (ch),
      .terminal (ch_terminal)
   );

   assign program_address = pc[AW-1:0];
   assign channel_address = ch;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ret_state   <= IDLE;
         pc          <= '0;
         size_q      <= '0;
         ch_last     <= '0;
         ldc_pend    <= 1'b0;
         efi_taken   <= 1'b0;
         issue_valid <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (run) begin
                  size_q    <= program_size;
                  ch_last   <= (n_channels == '0) ? '0 : n_channels - 1'b1;
                  pc        <= '0;
                  ldc_pend  <= 1'b0;
                  efi_taken <= 1'b0;
                  if (program_size == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state       <= RUN;
                     issue_valid <= 1'b1;
                     busy        <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (efi_trig) begin
                  state       <= EFI_WAIT;
                  ret_state   <= RUN;
                  efi_taken   <= 1'b1;
                  ldc_pend    <= ldc_pend | immediate_advance;
                  issue_valid <= 1'b0;
               end else if (single) begin
                  state       <= RESOLVE;
                  issue_valid <= 1'b0;
               end else if (ch_terminal) begin
                  ldc_pend  <= 1'b0;
                  efi_taken <= 1'b0;
                  if (finish) begin
                     state       <= DONE;
                     issue_valid <= 1'b0;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                  end else begin
                     pc <= next_pc[AW:0];
                  end
               end else begin
                  ldc_pend <= ldc_pend | immediate_advance;
               end
            end
            RESOLVE: begin
               if (efi_trig) begin
                  state     <= EFI_WAIT;
                  ret_state <= RESOLVE;
                  efi_taken <= 1'b1;
                  ldc_pend  <= ldc_pend | immediate_advance;
               end else begin
                  ldc_pend  <= 1'b0;
                  efi_taken <= 1'b0;
                  if (finish) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     pc          <= next_pc[AW:0];
                     state       <= RUN;
                     issue_valid <= 1'b1;
                  end
               end
            end
            EFI_WAIT: begin
               if (efi_done) begin
                  state       <= ret_state;
                  issue_valid <= (ret_state == RUN);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               issue_valid <= 1'b0;
               busy        <= 1'b0;
               done        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fcore_program_sequencer.sv
// Self-checking bench for fcore_program_sequencer: reactive prefetcher stimulus against a
// program-level model of issue order and completion time.
module tb_fcore_program_sequencer;

   logic        clock;
   logic        reset;
   logic        run;
   logic [12:0] program_size;
   logic [7:0]  n_channels;
   logic        immediate_advance;
   logic        efi_call;
   logic        efi_done;
   logic [11:0] program_address;
   logic [7:0]  channel_address;
   logic        issue_valid;
   logic        busy;
   logic        done;

   int n_vec;
   int n_err;

   fcore_program_sequencer #(
      .PROGRAM_DEPTH (4096),
      .MAX_CHANNELS  (255)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .run               (run),
      .program_size      (program_size),
      .n_channels        (n_channels),
      .immediate_advance (immediate_advance),
      .efi_call          (efi_call),
      .efi_done          (efi_done),
      .program_address   (program_address),
      .channel_address   (channel_address),
      .issue_valid       (issue_valid),
      .busy              (busy),
      .done              (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic clear_inputs();
      run               = 1'b0;
      immediate_advance = 1'b0;
      efi_call          = 1'b0;
      efi_done          = 1'b0;
   endtask

   // Runs one program with the bench acting as prefetcher and EFI accelerator.
   task automatic run_program(input int size, input int nch, input logic [15:0] ldc_m,
                              input logic [15:0] efi_m, input int d_fixed, input bit hold,
                              input bit noise, input string name);
      int          exp_pc[$];
      int          exp_ch[$];
      int          obs_pc[$];
      int          obs_ch[$];
      int          n_eff;
      int          mpc;
      int          n_instr;
      int          n_efi;
      int          body;
      int          sum_d;
      int          wait_cnt;
      int          done_cyc;
      int          exp_done;
      int          d;
      int          efi_pc;
      int          efi_ch;
      int          lim;
      bit          prev_v;
      int          prev_ch;
      logic [11:0] prev_pc;
      bit          trig;
      bit          word_ldc;
      bit          word_efi;
      bit          cur_efi;

      n_eff   = (nch == 0) ? 1 : nch;
      mpc     = 0;
      n_instr = 0;
      n_efi   = 0;
      while (mpc < size) begin
         for (int c = 0; c < n_eff; c++) begin
            exp_pc.push_back(mpc);
            exp_ch.push_back(c);
            if (c == 1 && efi_m[mpc]) begin
               exp_pc.push_back(mpc);
               exp_ch.push_back(c);
            end
         end
         if (efi_m[mpc]) n_efi++;
         n_instr++;
         mpc += ldc_m[mpc] ? 2 : 1;
      end
      body = (n_eff == 1) ? 2 * n_instr : n_instr * n_eff;

      sum_d    = 0;
      wait_cnt = 0;
      done_cyc = -1;
      efi_pc   = 0;
      efi_ch   = 0;
      prev_v   = 0;
      prev_ch  = 0;
      prev_pc  = '0;

      @(posedge clock); #1;
      clear_inputs();
      program_size = 13'(size);
      n_channels   = 8'(nch);
      run          = 1'b1;

      for (int cyc = 1; cyc <= 2000; cyc++) begin
         @(posedge clock); #1;
         if (issue_valid === 1'b1) begin
            obs_pc.push_back(int'(program_address));
            obs_ch.push_back(int'(channel_address));
            if (n_eff == 1) begin
               n_vec++;
               if (prev_v !== 1'b0) begin
                  n_err++;
                  $display("FAIL %s bubble cyc=%0d issue_valid=1 after issue, required 0", name, cyc);
               end
            end
         end
         if (wait_cnt > 0) begin
            n_vec++;
            if (issue_valid !== 1'b0 || int'(channel_address) != efi_ch ||
                int'(program_address) != efi_pc) begin
               n_err++;
               $display("FAIL %s efi_freeze cyc=%0d valid=%0b pc=%0d ch=%0d, required valid=0 pc=%0d ch=%0d",
                        name, cyc, issue_valid, program_address, channel_address, efi_pc, efi_ch);
            end
         end
         n_vec++;
         if (done === 1'b1) begin
            done_cyc = cyc;
            if (busy !== 1'b0) begin
               n_err++;
               $display("FAIL %s busy_at_done busy=%0b, required 0", name, busy);
            end
         end else if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s busy cyc=%0d busy=%0b, required 1", name, cyc, busy);
         end

         word_ldc = prev_v && prev_ch == 0 && prev_pc < 16 && ldc_m[prev_pc[3:0]];
         word_efi = prev_v && prev_ch == 0 && prev_pc < 16 && efi_m[prev_pc[3:0]];
         trig     = word_efi;
         cur_efi  = issue_valid && channel_address != 0 && program_address < 16 &&
                    efi_m[program_address[3:0]];
         run               = noise && (busy || done) && ($urandom_range(0, 3) == 0);
         immediate_advance = word_ldc;
         efi_done          = 1'b0;
         if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) efi_done = 1'b1;
         end else if (noise && $urandom_range(0, 5) == 0) begin
            efi_done = 1'b1;
         end
         if (trig) begin
            d        = (d_fixed > 0) ? d_fixed : int'($urandom_range(1, 6));
            wait_cnt = d;
            sum_d   += d;
            efi_pc   = int'(prev_pc);
            efi_ch   = (n_eff == 1) ? 0 : 1;
         end
         efi_call = trig || (hold && (wait_cnt > 0 || cur_efi));

         prev_v  = issue_valid;
         prev_ch = int'(channel_address);
         prev_pc = program_address;
         if (done_cyc >= 0) break;
      end

      if (done_cyc < 0) begin
         n_vec++;
         n_err++;
         $display("FAIL %s timeout done never seen within 2000 cycles", name);
      end

      n_vec++;
      if (obs_pc.size() != exp_pc.size()) begin
         n_err++;
         $display("FAIL %s issue_count got %0d, required %0d", name, obs_pc.size(), exp_pc.size());
      end
      lim = (obs_pc.size() < exp_pc.size()) ? obs_pc.size() : exp_pc.size();
      for (int i = 0; i < lim; i++) begin
         n_vec++;
         if (obs_pc[i] != exp_pc[i] || obs_ch[i] != exp_ch[i]) begin
            n_err++;
            $display("FAIL %s issue[%0d] pc=%0d ch=%0d, required pc=%0d ch=%0d",
                     name, i, obs_pc[i], obs_ch[i], exp_pc[i], exp_ch[i]);
         end
      end

      exp_done = 1 + body + n_efi + sum_d;
      if (done_cyc >= 0) begin
         n_vec++;
         if (done_cyc != exp_done) begin
            n_err++;
            $display("FAIL %s done_cycle got %0d, required %0d", name, done_cyc, exp_done);
         end
      end

      // done must be a single pulse and a run seen in DONE must not start anything
      for (int k = 0; k < 2; k++) begin
         @(posedge clock); #1;
         clear_inputs();
         n_vec++;
         if (done !== 1'b0 || issue_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s post_done[%0d] done=%0b valid=%0b busy=%0b, required 0 0 0",
                     name, k, done, issue_valid, busy);
         end
      end
   endtask

   task automatic check_zero_outputs(input string name);
      n_vec++;
      if (program_address !== '0 || channel_address !== '0 || issue_valid !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL %s outputs pc=%0d ch=%0d valid=%0b busy=%0b done=%0b, required all 0",
                  name, program_address, channel_address, issue_valid, busy, done);
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      program_size = '0;
      n_channels   = '0;
      reset        = 1'b0;
      #3;
      check_zero_outputs("reset_async");
      repeat (2) @(posedge clock);
      #1;
      check_zero_outputs("reset_held");
      reset = 1'b1;
      @(posedge clock); #1;
      check_zero_outputs("reset_idle");
   endtask

   task automatic test_basic_sweep();
      run_program(3, 4, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, "basic_sweep");
   endtask

   task automatic test_ldc_sweep();
      run_program(4, 3, 16'h0002, 16'h0000, 0, 1'b0, 1'b0, "ldc_sweep");
      run_program(5, 2, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, "ldc_overhang");
   endtask

   task automatic test_single_channel();
      run_program(4, 1, 16'h0001, 16'h0000, 0, 1'b0, 1'b0, "single_channel");
      run_program(3, 0, 16'h0000, 16'h0002, 3, 1'b0, 1'b0, "single_efi");
   endtask

   task automatic test_efi_hold();
      run_program(4, 4, 16'h0000, 16'h0004, 10, 1'b1, 1'b0, "efi_hold");
   endtask

   task automatic test_zero_size();
      run_program(0, 4, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, "zero_size");
   endtask

   task automatic test_back_to_back();
      run_program(5, 3, 16'h0004, 16'h0008, 2, 1'b0, 1'b1, "busy_run_ignored");
      run_program(2, 2, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, "back_to_back");
   endtask

   task automatic test_reset_mid_sweep();
      bit seen;
      seen = 1'b0;
      @(posedge clock); #1;
      clear_inputs();
      program_size = 13'd8;
      n_channels   = 8'd4;
      run          = 1'b1;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(posedge clock); #1;
         run = 1'b0;
         if (issue_valid === 1'b1 && program_address == 12'd5 && channel_address == 8'd2) begin
            seen = 1'b1;
            break;
         end
      end
      n_vec++;
      if (!seen) begin
         n_err++;
         $display("FAIL reset_mid reach pc=5 ch=2 not reached, required within 200 cycles");
      end
      #2;
      reset = 1'b0;
      #1;
      check_zero_outputs("reset_mid_async");
      repeat (3) begin
         @(posedge clock); #1;
         check_zero_outputs("reset_mid_no_done");
      end
      reset = 1'b1;
      run_program(3, 2, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, "restart_after_reset");
   endtask

   task automatic test_random();
      int          size;
      int          nch;
      logic [15:0] ldc_m;
      logic [15:0] efi_m;
      for (int t = 0; t < 14; t++) begin
         size  = int'($urandom_range(0, 12));
         nch   = int'($urandom_range(0, 5));
         ldc_m = '0;
         efi_m = '0;
         for (int b = 0; b < 16; b++) begin
            ldc_m[b] = ($urandom_range(0, 3) == 0);
            efi_m[b] = ($urandom_range(0, 5) == 0);
         end
         run_program(size, nch, ldc_m, efi_m, 0, 1'b0, 1'b1, $sformatf("random%0d", t));
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic_sweep();
      test_ldc_sweep();
      test_single_channel();
      test_efi_hold();
      test_zero_size();
      test_back_to_back();
      test_reset_mid_sweep();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
